// File: rtl/ser2par_gearbox.sv
// rtl/ser2par_gearbox.sv - serial-to-parallel gearbox packing RATIO beats of DIN_W bits per word
// Optional early word termination (din_last/dout_last/dout_keep) under SER2PAR_LAST_FLUSH_EN.
module ser2par_gearbox #(
  parameter int DIN_W     = 1,
  parameter int RATIO     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DIN_W-1:0]         din,
  input  logic                     din_vld,
  input  logic                     din_rdy,
`ifdef SER2PAR_LAST_FLUSH_EN
  input  logic                     din_last,
  output logic                     dout_last,
  output logic [RATIO-1:0]         dout_keep,
`endif
  output logic [DIN_W*RATIO-1:0]   dout,
  output logic                     dout_vld,
  output logic                     dout_rdy,
  output logic                     busy
);

  localparam int DOUT_W = DIN_W * RATIO;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  slot;
  logic [DOUT_W-1:0] asm_q;
  logic [DOUT_W-1:0] merged;
  logic [DOUT_W-1:0] word;
  logic              asm_full;
  logic              wr_en;
  logic              rd_en;
  logic              out_free;
  logic              final_beat;

  assign wr_en    = din_vld & dout_rdy;
  assign rd_en    = dout_vld & din_rdy;
  assign out_free = ~dout_vld | rd_en;
  // The hold stage is the only thing that can stall the input side.
  assign dout_rdy = ~asm_full;
  assign busy     = (cnt != '0) | asm_full | dout_vld;
  assign slot     = (LSB_FIRST != 0) ? cnt : CNT_LAST - cnt;

  always_comb begin
    merged = asm_q;
    for (int s = 0; s < RATIO; s++) begin
      if (CNT_W'(s) == slot) merged[s*DIN_W +: DIN_W] = din;
    end
  end

`ifdef SER2PAR_LAST_FLUSH_EN
  logic [RATIO-1:0] keep_mask;
  logic [RATIO-1:0] asm_keep;
  logic             asm_last;

  // A slot holds a real beat when its beat index is not past the current one.
  always_comb begin
    word      = merged;
    keep_mask = '0;
    for (int s = 0; s < RATIO; s++) begin
      if (CNT_W'((LSB_FIRST != 0) ? s : RATIO - 1 - s) <= cnt) keep_mask[s] = 1'b1;
      else word[s*DIN_W +: DIN_W] = '0;
    end
  end

  assign final_beat = wr_en & ((cnt == CNT_LAST) | din_last);
`else
  assign word       = merged;
  assign final_beat = wr_en & (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      asm_q    <= '0;
      asm_full <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
`ifdef SER2PAR_LAST_FLUSH_EN
      asm_keep  <= '0;
      asm_last  <= 1'b0;
      dout_keep <= '0;
      dout_last <= 1'b0;
`endif
    end else begin
      if (wr_en) begin
        if (final_beat) cnt <= '0;
        else begin
          cnt   <= cnt + 1'b1;
          asm_q <= merged;
        end
      end

      if (asm_full) begin
        if (out_free) begin
          dout     <= asm_q;
          dout_vld <= 1'b1;
          asm_full <= 1'b0;
`ifdef SER2PAR_LAST_FLUSH_EN
          dout_keep <= asm_keep;
          dout_last <= asm_last;
`endif
        end
      end else if (final_beat) begin
        if (out_free) begin
          dout     <= word;
          dout_vld <= 1'b1;
`ifdef SER2PAR_LAST_FLUSH_EN
          dout_keep <= keep_mask;
          dout_last <= din_last;
`endif
        end else begin
          asm_q    <= word;
          asm_full <= 1'b1;
`ifdef SER2PAR_LAST_FLUSH_EN
          asm_keep <= keep_mask;
          asm_last <= din_last;
`endif
        end
      end else if (rd_en) begin
        dout_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ser2par_gearbox.sv
// tb/tb_ser2par_gearbox.sv - self-checking bench for ser2par_gearbox
// Optional SER2PAR_LAST_FLUSH_EN ports are exercised when the macro is defined.
module tb_ser2par_gearbox;

`ifdef SER2PAR_LAST_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  typedef struct {
    logic [7:0] word;
    logic [3:0] keep;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_vld = 1'b0;
  logic       din_rdy = 1'b0;
  logic       din_last = 1'b0;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_vld, b_vld, c_vld;
  logic       a_rdy, b_rdy, c_rdy;
  logic       a_busy, b_busy, c_busy;
  logic [7:0] obs_dout;
  logic       obs_vld, obs_rdy, obs_busy;
`ifdef SER2PAR_LAST_FLUSH_EN
  logic       a_last, b_last, c_last;
  logic [3:0] a_keep, b_keep;
  logic [0:0] c_keep;
  logic [3:0] obs_keep;
  logic       obs_last;
`endif

  int   sel = 0;
  int   cfg_w = 2, cfg_r = 4, cfg_lsb = 1;
  int   tests = 0, fails = 0;
  int   k = 0;
  logic [7:0] acc_word = '0;
  logic [3:0] acc_keep = '0;
  logic       acc;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ser2par_gearbox #(.DIN_W(2), .RATIO(4), .LSB_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din[1:0]), .din_vld(din_vld), .din_rdy(din_rdy),
`ifdef SER2PAR_LAST_FLUSH_EN
    .din_last(din_last), .dout_last(a_last), .dout_keep(a_keep),
`endif
    .dout(a_dout), .dout_vld(a_vld), .dout_rdy(a_rdy), .busy(a_busy));

  ser2par_gearbox #(.DIN_W(2), .RATIO(4), .LSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din[1:0]), .din_vld(din_vld), .din_rdy(din_rdy),
`ifdef SER2PAR_LAST_FLUSH_EN
    .din_last(din_last), .dout_last(b_last), .dout_keep(b_keep),
`endif
    .dout(b_dout), .dout_vld(b_vld), .dout_rdy(b_rdy), .busy(b_busy));

  ser2par_gearbox #(.DIN_W(8), .RATIO(1), .LSB_FIRST(1)) u_c (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
`ifdef SER2PAR_LAST_FLUSH_EN
    .din_last(din_last), .dout_last(c_last), .dout_keep(c_keep),
`endif
    .dout(c_dout), .dout_vld(c_vld), .dout_rdy(c_rdy), .busy(c_busy));

  always_comb begin
    case (sel)
      0:       begin obs_dout = a_dout; obs_vld = a_vld; obs_rdy = a_rdy; obs_busy = a_busy; end
      1:       begin obs_dout = b_dout; obs_vld = b_vld; obs_rdy = b_rdy; obs_busy = b_busy; end
      default: begin obs_dout = c_dout; obs_vld = c_vld; obs_rdy = c_rdy; obs_busy = c_busy; end
    endcase
`ifdef SER2PAR_LAST_FLUSH_EN
    case (sel)
      0:       begin obs_keep = a_keep; obs_last = a_last; end
      1:       begin obs_keep = b_keep; obs_last = b_last; end
      default: begin obs_keep = {3'b000, c_keep}; obs_last = c_last; end
    endcase
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int s, input int w, input int r, input int lsb);
    sel = s; cfg_w = w; cfg_r = r; cfg_lsb = lsb;
  endtask

  // Reference: a word is the OR of each accepted beat shifted into its slot.
  task automatic model_beat(input logic [7:0] d, input logic l);
    int   slot;
    int   bi;
    exp_t e;
    bi   = int'(d) & ((1 << cfg_w) - 1);
    slot = (cfg_lsb != 0) ? k : cfg_r - 1 - k;
    acc_word = acc_word | 8'(bi << (slot * cfg_w));
    acc_keep = acc_keep | 4'(1 << slot);
    if (k == cfg_r - 1 || (l && FLUSH)) begin
      e.word = acc_word; e.keep = acc_keep; e.last = l && FLUSH;
      exp_q.push_back(e);
      acc_word = '0; acc_keep = '0; k = 0;
    end else begin
      k++;
    end
  endtask

  task automatic check_state();
    chk("dout_vld", obs_vld, exp_q.size() > 0);
    chk("dout_rdy", obs_rdy, exp_q.size() < 2);
    chk("busy", obs_busy, (k != 0) || (exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("dout", obs_dout, exp_q[0].word);
`ifdef SER2PAR_LAST_FLUSH_EN
      chk("dout_keep", obs_keep, exp_q[0].keep);
      chk("dout_last", obs_last, exp_q[0].last);
`endif
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [7:0] d, input logic v, input logic l, input logic r,
                      output logic accepted);
    logic wr, rd;
    din = d; din_vld = v; din_last = l; din_rdy = r;
    #1;
    wr = v & obs_rdy;
    rd = obs_vld & r;
    accepted = wr;
    @(posedge clk);
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    if (wr) model_beat(d, l);
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset();
    din_vld = 1'b0; din_rdy = 1'b0; din_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", obs_dout, 0);
    chk("rst_vld", obs_vld, 0);
    chk("rst_rdy", obs_rdy, 1);
    chk("rst_busy", obs_busy, 0);
`ifdef SER2PAR_LAST_FLUSH_EN
    chk("rst_keep", obs_keep, 0);
    chk("rst_last", obs_last, 0);
`endif
    exp_q.delete(); k = 0; acc_word = '0; acc_keep = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      step(8'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 6, acc);
    for (int i = 0; i < 6; i++) step(8'h00, 1'b0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    @(negedge clk);
    // LSB-first ordering, DIN_W=2 RATIO=4
    cfg(0, 2, 4, 1);
    do_reset();
    step(8'd1, 1, 0, 1, acc); step(8'd2, 1, 0, 1, acc);
    step(8'd3, 1, 0, 1, acc); step(8'd0, 1, 0, 1, acc);
    chk("ord_lsb_vld", obs_vld, 1);
    chk("ord_lsb_dout", obs_dout, 8'h39);
    step(8'd0, 0, 0, 1, acc);
    chk("ord_lsb_vld_drop", obs_vld, 0);

    // backpressure: two words fill output and hold stages
    for (int i = 0; i < 8; i++) begin
      step(8'(i < 4 ? (i == 0 ? 1 : i == 1 ? 2 : i == 2 ? 3 : 0)
                    : (i == 4 ? 2 : i == 5 ? 1 : i == 6 ? 0 : 3)), 1, 0, 0, acc);
      chk("bp_accept", acc, 1);
    end
    chk("bp_rdy_low", obs_rdy, 0);
    chk("bp_first", obs_dout, 8'h39);
    step(8'd1, 1, 0, 0, acc);
    chk("bp_stall", acc, 0);
    step(8'd1, 1, 0, 1, acc);
    chk("bp_stall2", acc, 0);
    chk("bp_second", obs_dout, 8'hC6);
    chk("bp_rdy_back", obs_rdy, 1);
    step(8'd0, 0, 0, 1, acc);
    chk("bp_empty", obs_vld, 0);

    // reset in the middle of a word
    step(8'd3, 1, 0, 1, acc); step(8'd3, 1, 0, 1, acc);
    do_reset();
    step(8'd3, 1, 0, 1, acc); step(8'd0, 1, 0, 1, acc);
    step(8'd1, 1, 0, 1, acc); step(8'd2, 1, 0, 1, acc);
    chk("rst_clean_word", obs_dout, 8'h93);
    step(8'd0, 0, 0, 1, acc);

`ifdef SER2PAR_LAST_FLUSH_EN
    step(8'd3, 1, 0, 1, acc); step(8'd1, 1, 1, 1, acc);
    chk("flush_dout", obs_dout, 8'h07);
    chk("flush_keep", obs_keep, 4'b0011);
    chk("flush_last", obs_last, 1);
    step(8'd1, 1, 0, 1, acc); step(8'd2, 1, 0, 1, acc);
    step(8'd3, 1, 0, 1, acc); step(8'd0, 1, 0, 1, acc);
    chk("full_dout", obs_dout, 8'h39);
    chk("full_keep", obs_keep, 4'b1111);
    chk("full_last", obs_last, 0);
    step(8'd0, 0, 0, 1, acc);
`endif
    random_run(300);

    // MSB-first ordering
    cfg(1, 2, 4, 0);
    do_reset();
    step(8'd1, 1, 0, 1, acc); step(8'd2, 1, 0, 1, acc);
    step(8'd3, 1, 0, 1, acc); step(8'd0, 1, 0, 1, acc);
    chk("ord_msb_dout", obs_dout, 8'h6C);
    step(8'd0, 0, 0, 1, acc);
    random_run(300);

    // full rate, DIN_W=8 RATIO=1
    cfg(2, 8, 1, 1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(8'(i), 1, 0, 1, acc);
      chk("fr_rdy", obs_rdy, 1);
      chk("fr_dout", obs_dout, i);
    end
    random_run(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
